// File: rtl/reg_file_param_if.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_param_if
// Brief    : Write/reserve/read bundle for the scoreboarded register file.
// Revision : 1.0
// ============================================================================
interface reg_file_param_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic              write_en;
    logic [ADDR_W-1:0] waddr;
    logic [WIDTH-1:0]  data_in;
    logic [ADDR_W-1:0] raddrA;
    logic [ADDR_W-1:0] raddrB;
    logic              rsv_en;
    logic [ADDR_W-1:0] rsv_addr;
    logic [WIDTH-1:0]  data_outA;
    logic [WIDTH-1:0]  data_outB;
    logic              busyA;
    logic              busyB;
    logic [ADDR_W:0]   busy_cnt;

    modport master (
        output write_en, waddr, data_in, raddrA, raddrB, rsv_en, rsv_addr,
        input  data_outA, data_outB, busyA, busyB, busy_cnt
    );

    modport slave (
        input  write_en, waddr, data_in, raddrA, raddrB, rsv_en, rsv_addr,
        output data_outA, data_outB, busyA, busyB, busy_cnt
    );
endinterface
`default_nettype wire

// File: rtl/reg_file_param.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_param
// Brief    : Two-read/one-write register file with per-register busy bits.
// Revision : 1.0
// ============================================================================
module reg_file_param #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0
) (
    input  wire logic       clk,
    input  wire logic       reset,
    reg_file_param_if.slave bus
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0] r_busy;
    logic [CNT_W-1:0] r_cnt;
    logic             r_run;

    logic [DEPTH-1:0] w_wr_sel;
    logic [DEPTH-1:0] w_rsv_sel;
    logic [DEPTH-1:0] w_busy_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [WIDTH-1:0] w_data_a;
    logic [WIDTH-1:0] w_data_b;
    logic             w_busy_a;
    logic             w_busy_b;

    // r_run holds off updates on the first edge after reset release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_run <= 1'b0;
        end else begin
            r_run <= 1'b1;
        end
    end

    // Out-of-range and hardwired-zero addresses decode to no select line.
    always_comb begin
        w_wr_sel  = '0;
        w_rsv_sel = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!(ZERO_REG != 0 && i == 0)) begin
                w_wr_sel[i]  = r_run && bus.write_en && (bus.waddr == ADDR_W'(i));
                w_rsv_sel[i] = r_run && bus.rsv_en && (bus.rsv_addr == ADDR_W'(i));
            end
        end
        w_busy_nxt = (r_busy & ~w_wr_sel) | w_rsv_sel;
        w_cnt_nxt  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_cnt_nxt = w_cnt_nxt + CNT_W'(w_busy_nxt[i]);
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_mem[gi] <= '0;
                end else if (w_wr_sel[gi]) begin
                    r_mem[gi] <= bus.data_in;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy <= '0;
            r_cnt  <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            r_cnt  <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_data_a = '0;
        w_data_b = '0;
        w_busy_a = 1'b0;
        w_busy_b = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (bus.raddrA == ADDR_W'(i)) begin
                w_data_a = r_mem[i];
                w_busy_a = r_busy[i];
            end
            if (bus.raddrB == ADDR_W'(i)) begin
                w_data_b = r_mem[i];
                w_busy_b = r_busy[i];
            end
        end
        if (BYPASS != 0 && (|w_wr_sel)) begin
            if (bus.raddrA == bus.waddr) begin
                w_data_a = bus.data_in;
                w_busy_a = 1'b0;
            end
            if (bus.raddrB == bus.waddr) begin
                w_data_b = bus.data_in;
                w_busy_b = 1'b0;
            end
        end
    end

    assign bus.data_outA = w_data_a;
    assign bus.data_outB = w_data_b;
    assign bus.busyA     = w_busy_a;
    assign bus.busyB     = w_busy_b;
    assign bus.busy_cnt  = r_cnt;

endmodule
`default_nettype wire

// File: doc/reg_file_param.md
REG_FILE_PARAM -- requirements
Module: reg_file_param

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, data bits per register.
REQ-002 SHALL provide parameter DEPTH, default 8, number of registers (2..256); ADDR_W = clog2(DEPTH).
REQ-003 SHALL provide parameter BYPASS, default 1, 1 = same-cycle write-to-read forwarding.
REQ-004 SHALL provide parameter ZERO_REG, default 0, 1 = register 0 hardwired to zero.
REQ-005 SHALL provide port clk  input  1  single clock, rising-edge active.
REQ-006 SHALL provide port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL provide port write_en  input  1  write strobe.
REQ-008 SHALL provide port waddr  input  ADDR_W  write address.
REQ-009 SHALL provide port data_in  input  WIDTH  write data.
REQ-010 SHALL provide port raddrA  input  ADDR_W  read address A.
REQ-011 SHALL provide port raddrB  input  ADDR_W  read address B.
REQ-012 SHALL provide port rsv_en  input  1  reserve strobe, marks a register pending.
REQ-013 SHALL provide port rsv_addr  input  ADDR_W  register to reserve.
REQ-014 SHALL provide port data_outA  output  WIDTH  read data A.
REQ-015 SHALL provide port data_outB  output  WIDTH  read data B.
REQ-016 SHALL provide port busyA  output  1  register at raddrA is reserved, not yet written.
REQ-017 SHALL provide port busyB  output  1  register at raddrB is reserved, not yet written.
REQ-018 SHALL provide port busy_cnt  output  ADDR_W+1  count of reserved registers.

Function
REQ-019 Storage SHALL be DEPTH x WIDTH registers plus a DEPTH-bit busy vector.
REQ-020 Write: on rising clk with write_en=1 and waddr valid, reg[waddr] <= data_in; busy[waddr] <= 0.
REQ-021 Reads SHALL be combinational: data_outX = reg[raddrX], zero latency.
REQ-022 BYPASS=1: write_en=1 and raddrX==waddr SHALL drive data_outX = data_in and busyX = 0 in that cycle; BYPASS=0: old contents and old busy until the edge.
REQ-023 Reserve: on rising clk with rsv_en=1, busy[rsv_addr] <= 1.
REQ-024 Simultaneous write and reserve to the same address: data SHALL be written and busy SHALL end at 1 (reserve wins).
REQ-025 Reserving an already-busy register SHALL leave it busy with busy_cnt unchanged; writing a non-busy register SHALL leave busy_cnt unchanged.
REQ-026 busy_cnt SHALL equal popcount(busy) after every edge, registered, never wrapping (max DEPTH).
REQ-027 ZERO_REG=1: address 0 SHALL read 0, never busy; writes and reserves to 0 ignored.
REQ-028 Address >= DEPTH (DEPTH not power of 2): reads return 0 with busy 0; writes and reserves ignored.
REQ-029 Read ports SHALL be independent; raddrA==raddrB returns identical values on both.
REQ-030 Inputs SHALL be sampled only at rising clk; no other state changes except reset.

Reset
REQ-031 reset=1 SHALL asynchronously clear all registers, busy vector and busy_cnt to 0 without waiting for clk.
REQ-032 While reset=1, write_en and rsv_en SHALL be ignored; outputs read 0.
REQ-033 Reset deassertion SHALL take effect at the next rising clk; a write or reserve pending at deassertion is not applied.
REQ-034 Reset mid-operation (busy_cnt>0, write in flight) SHALL discard all state; no partial update.

Verification
REQ-035 Write/read: reset, write 8'hFF to reg 2, then raddrA=2 -> data_outA=8'hFF, busyA=0.
REQ-036 Write gating: write_en=0, waddr=3, data_in=8'hCD, raddrA=3 -> data_outA stays 8'h00 after the edge.
REQ-037 Bypass: write_en=1, waddr=1, data_in=8'h01, raddrB=1, BYPASS=1 -> data_outB=8'h01 before the edge; BYPASS=0 -> 8'h00 until the edge.
REQ-038 Scoreboard: reserve 4 and 5 -> busy_cnt=2, busyA=1 for raddrA=4; write reg 4 -> busy_cnt=1; same-cycle write and reserve of 5 -> busy stays 1.
REQ-039 Async reset: with regs written and busy_cnt=3, assert reset between edges -> all outputs 0 immediately.
REQ-040 Params: WIDTH=16, DEPTH=6, ZERO_REG=1 -> write 16'hBEEF to reg 0 or 7 ignored, reads 0; reg 5 round-trips 16'hBEEF.
